// File: rtl/lif_node_n.sv
// rtl/lif_node_n.sv - leaky integrate-and-fire node with N gated input channels
// Two stages: input buffers, then leak/integrate/fire with a refractory hold-off.
module lif_node_n #(
   parameter int N_IN        = 4,
   parameter int W_IN        = 4,
   parameter int W_MEM       = 8,
   parameter int LEAK_SHIFT  = 3,
   parameter int REFRACT_CYC = 2,
   parameter int W_CNT       = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [N_IN*W_IN-1:0]   in_bus,
   input  logic [N_IN-1:0]        in_en,
   input  logic [W_MEM-1:0]       thresh,
   output logic                   spike,
   output logic [W_MEM-1:0]       mem,
   output logic                   refractory,
   output logic [W_CNT-1:0]       spike_cnt
);

   localparam int W_SUM = W_IN + $clog2(N_IN);

   typedef enum logic {INTEG, REFRACT} state_t;

   state_t                 state_q, state_d;
   logic [N_IN*W_IN-1:0]   bus_q;
   logic [N_IN-1:0]        en_q;
   logic [W_MEM-1:0]       mem_q, mem_d;
   logic [3:0]             rcnt_q, rcnt_d;
   logic                   spike_q, spike_d;
   logic [W_CNT-1:0]       cnt_q, cnt_d;

   logic [W_SUM-1:0]       sum_w;
   logic [W_MEM-1:0]       leak_w;
   logic [W_MEM:0]         nxt_w;
   logic [W_MEM-1:0]       sat_w;
   logic                   fire_w;

   always_comb begin
      sum_w = '0;
      for (int i = 0; i < N_IN; i++) begin
         if (en_q[i]) begin
            sum_w = sum_w + W_SUM'(bus_q[i*W_IN +: W_IN]);
         end
      end
   end

   // The extra top bit catches overflow so the clamp happens before the threshold compare.
   always_comb begin
      leak_w = mem_q >> LEAK_SHIFT;
      nxt_w  = {1'b0, mem_q} - {1'b0, leak_w} + (W_MEM+1)'(sum_w);
      sat_w  = nxt_w[W_MEM] ? '1 : nxt_w[W_MEM-1:0];
      fire_w = (thresh != '0) && (sat_w >= thresh);
   end

   always_comb begin
      state_d = state_q;
      mem_d   = mem_q;
      rcnt_d  = rcnt_q;
      spike_d = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         INTEG: begin
            if (fire_w) begin
               mem_d   = '0;
               spike_d = 1'b1;
               cnt_d   = cnt_q + W_CNT'(1);
               if (REFRACT_CYC != 0) begin
                  state_d = REFRACT;
                  rcnt_d  = 4'(REFRACT_CYC);
               end
            end else begin
               mem_d = sat_w;
            end
         end
         REFRACT: begin
            mem_d  = '0;
            rcnt_d = rcnt_q - 4'd1;
            if (rcnt_q <= 4'd1) begin
               state_d = INTEG;
               rcnt_d  = 4'd0;
            end
         end
         default: state_d = INTEG;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         bus_q   <= '0;
         en_q    <= '0;
         state_q <= INTEG;
         mem_q   <= '0;
         rcnt_q  <= '0;
         spike_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         bus_q   <= in_bus;
         en_q    <= in_en;
         state_q <= state_d;
         mem_q   <= mem_d;
         rcnt_q  <= rcnt_d;
         spike_q <= spike_d;
         cnt_q   <= cnt_d;
      end
   end

   assign spike      = spike_q;
   assign mem        = mem_q;
   assign refractory = (state_q == REFRACT);
   assign spike_cnt  = cnt_q;

endmodule

// File: tb/tb_lif_node_n.sv
// tb/tb_lif_node_n.sv - self-checking bench for lif_node_n
// Arithmetic model updated on each rising edge, compared on every falling edge.
module tb_lif_node_n;

   localparam int N_IN  = 4;
   localparam int W_IN  = 4;
   localparam int W_MEM = 8;
   localparam int LS    = 3;
   localparam int RC    = 2;
   localparam int W_CNT = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] in_bus = '0;
   logic [3:0]  in_en = '0;
   logic [7:0]  thresh = '0;
   logic        spike;
   logic [7:0]  mem;
   logic        refractory;
   logic [7:0]  spike_cnt;

   lif_node_n #(
      .N_IN(N_IN), .W_IN(W_IN), .W_MEM(W_MEM),
      .LEAK_SHIFT(LS), .REFRACT_CYC(RC), .W_CNT(W_CNT)
   ) dut (
      .clk(clk), .reset(reset), .in_bus(in_bus), .in_en(in_en), .thresh(thresh),
      .spike(spike), .mem(mem), .refractory(refractory), .spike_cnt(spike_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   bit chk_on = 1'b0;

   int m_buf [N_IN];
   bit m_en  [N_IN];
   int m_mem = 0;
   int m_rc  = 0;
   int m_spk = 0;
   int m_cnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: a potential that leaks by 1/2^LS, clamps at full scale, and sits out RC cycles after firing.
   always @(posedge clk) begin
      int sum;
      int nxt;
      if (reset) begin
         for (int i = 0; i < N_IN; i++) begin
            m_buf[i] = 0;
            m_en[i]  = 1'b0;
         end
         m_mem = 0; m_rc = 0; m_spk = 0; m_cnt = 0;
      end else begin
         sum = 0;
         for (int i = 0; i < N_IN; i++) if (m_en[i]) sum += m_buf[i];
         if (m_rc > 0) begin
            m_mem = 0;
            m_spk = 0;
            m_rc--;
         end else begin
            nxt = m_mem - m_mem / (1 << LS) + sum;
            if (nxt > (1 << W_MEM) - 1) nxt = (1 << W_MEM) - 1;
            if (thresh != 0 && nxt >= int'(thresh)) begin
               m_spk = 1;
               m_mem = 0;
               m_cnt = (m_cnt + 1) % (1 << W_CNT);
               m_rc  = RC;
            end else begin
               m_mem = nxt;
               m_spk = 0;
            end
         end
         for (int i = 0; i < N_IN; i++) begin
            m_buf[i] = int'(in_bus[i*W_IN +: W_IN]);
            m_en[i]  = in_en[i];
         end
      end
   end

   always @(negedge clk) begin
      if (chk_on) begin
         chk("model_spike", spike, m_spk);
         chk("model_mem", mem, m_mem);
         chk("model_refractory", refractory, m_rc > 0);
         chk("model_spike_cnt", spike_cnt, m_cnt);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      in_bus = '0; in_en = '0; thresh = '0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   initial begin
      int leak_exp [4] = '{8, 7, 7, 7};
      int sat_exp  [7] = '{60, 113, 159, 200, 235, 255, 255};
      int spikes;
      int last;

      // Reset held with full drive: everything stays clear, including one edge after release.
      in_bus = 16'hFFFF; in_en = 4'hF; thresh = 8'd20;
      reset = 1'b1;
      tick();
      chk_on = 1'b1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_mem", mem, 0);
         chk("rst_spike", spike, 0);
         chk("rst_cnt", spike_cnt, 0);
         chk("rst_refr", refractory, 0);
         if (k == 0) tick();
      end
      reset = 1'b0;
      tick();
      chk("post_rst_mem", mem, 0);
      chk("post_rst_spike", spike, 0);
      chk("post_rst_refr", refractory, 0);
      tick();
      chk("post_rst_fire", spike, 1);

      // Single 5555 pulse fires two edges after presentation.
      do_reset();
      in_bus = 16'h5555; in_en = 4'hF; thresh = 8'd20;
      tick();
      in_bus = '0;
      tick();
      chk("pulse_spike", spike, 1);
      chk("pulse_mem", mem, 0);
      chk("pulse_refr1", refractory, 1);
      chk("pulse_cnt", spike_cnt, 1);
      tick();
      chk("pulse_spike_off", spike, 0);
      chk("pulse_refr2", refractory, 1);
      tick();
      chk("pulse_refr_end", refractory, 0);

      // Leak settles at 7 because 7 >> 3 is zero.
      do_reset();
      thresh = 8'd200; in_en = 4'hF; in_bus = 16'h0008;
      tick();
      in_bus = '0;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("leak_mem", mem, leak_exp[k]);
      end

      // Saturation with firing disabled.
      do_reset();
      thresh = 8'd0; in_en = 4'hF; in_bus = 16'hFFFF;
      tick();
      for (int k = 0; k < 7; k++) begin
         tick();
         chk("sat_mem", mem, sat_exp[k]);
         chk("sat_spike", spike, 0);
      end

      // Channel masking.
      do_reset();
      in_en = 4'b0001; in_bus = 16'hFFFF; thresh = 8'd15;
      tick();
      tick();
      chk("mask1_spike", spike, 1);
      do_reset();
      in_en = 4'b0000; in_bus = 16'hFFFF; thresh = 8'd15;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("mask0_spike", spike, 0);
         chk("mask0_mem", mem, 0);
      end

      // Mixed channels and a threshold change mid-integration.
      do_reset();
      in_en = 4'b1010; in_bus = 16'h1234; thresh = 8'd0;
      for (int k = 0; k < 6; k++) tick();
      thresh = 8'd25;
      for (int k = 0; k < 8; k++) tick();
      in_en = 4'b0111; thresh = 8'd9;
      for (int k = 0; k < 8; k++) tick();

      // Sustained drive: period of RC+1 and counter wrap after 256 spikes.
      do_reset();
      in_bus = 16'h5555; in_en = 4'hF; thresh = 8'd20;
      tick();
      spikes = 0;
      last = 0;
      for (int n = 0; n < 1000; n++) begin
         tick();
         if (spike === 1'b1) begin
            if (spikes > 0) chk("period", n - last, RC + 1);
            last = n;
            spikes++;
            if (spikes == 255) chk("cnt_255", spike_cnt, 255);
            if (spikes == 256) begin
               chk("cnt_wrap", spike_cnt, 0);
               break;
            end
         end
      end
      chk("spikes_seen", spikes, 256);
      chk("in_refract_before_rst", refractory, 1);

      // Reset wins mid-refractory.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_refr_refr", refractory, 0);
      chk("rst_refr_mem", mem, 0);
      chk("rst_refr_spike", spike, 0);

      // Reset wins over a pending fire.
      tick();
      tick();
      chk("pre_fire_cnt", spike_cnt, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_fire_spike", spike, 0);
      chk("rst_fire_cnt", spike_cnt, 0);
      tick();
      chk_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/lif_node_n.md
LIF_NODE_N -- requirements
Module: lif_node_n

Interface
- REQ-001: Parameter N_IN, default 4: number of input channels, 1..8.
- REQ-002: Parameter W_IN, default 4: bits per input channel, unsigned.
- REQ-003: Parameter W_MEM, default 8: membrane potential width, unsigned, W_MEM >= W_IN+3.
- REQ-004: Parameter LEAK_SHIFT, default 3: leak = mem >> LEAK_SHIFT per integrating cycle.
- REQ-005: Parameter REFRACT_CYC, default 2: refractory length in cycles, 0..15.
- REQ-006: Parameter W_CNT, default 8: spike counter width.
- REQ-007: clk  input  1  sole clock, all state updates on rising edge.
- REQ-008: reset  input  1  synchronous, active-high reset.
- REQ-009: in_bus  input  N_IN*W_IN  packed channel values; channel i at bits [i*W_IN +: W_IN].
- REQ-010: in_en  input  N_IN  per-channel enable; 0 forces that channel to contribute 0.
- REQ-011: thresh  input  W_MEM  firing threshold; 0 disables firing.
- REQ-012: spike  output  1  one-cycle registered fire pulse.
- REQ-013: mem  output  W_MEM  registered membrane potential.
- REQ-014: refractory  output  1  high while in REFRACT state.
- REQ-015: spike_cnt  output  W_CNT  registered count of spikes, wraps modulo 2^W_CNT.

Function
- REQ-016: Stage 1 shall register in_bus and in_en every cycle into input buffers, regardless of state.
- REQ-017: Stage 2 shall form sum = sum of buffered channels with buffered enable set, width W_IN+clog2(N_IN), no overflow.
- REQ-018: States: INTEG, REFRACT; the block shall leave reset in INTEG.
- REQ-019: In INTEG: nxt = mem - (mem >> LEAK_SHIFT) + sum, computed at W_MEM+1 bits, saturated to 2^W_MEM-1.
- REQ-020: In INTEG, if thresh != 0 and nxt >= thresh: spike <= 1, mem <= 0, spike_cnt += 1; go to REFRACT with rcnt <= REFRACT_CYC, or stay in INTEG when REFRACT_CYC = 0.
- REQ-021: In INTEG otherwise: mem <= nxt, spike <= 0.
- REQ-022: In REFRACT: mem held 0, spike 0, buffered inputs discarded, rcnt decrements; return to INTEG on the edge where rcnt goes 1 -> 0.
- REQ-023: Latency: input presented before edge k is buffered at edge k and affects mem/spike at edge k+1.
- REQ-024: Under continuous supra-threshold drive, the block shall fire with period REFRACT_CYC+1 cycles.
- REQ-025: thresh is sampled combinationally in stage 2 and is not buffered; changes take effect on the next edge.
- REQ-026: Saturation: mem shall never wrap; the clamp applies before the threshold compare.

Reset
- REQ-027: While reset is high at an edge: input buffers, mem, rcnt, spike_cnt <= 0; spike <= 0; state <= INTEG.
- REQ-028: Reset asserted mid-REFRACT or coincident with a fire condition shall win; no spike and no count increment.
- REQ-029: The first post-reset edge shall only buffer inputs; mem stays 0 until the second edge.

Verification (defaults: N_IN=4, W_IN=4, W_MEM=8, LEAK_SHIFT=3, REFRACT_CYC=2)
- REQ-030: Reset 2 cycles with in_bus=16'hFFFF, in_en=4'hF, thresh=20 -> mem=0, spike=0, spike_cnt=0, refractory=0 during and 1 cycle after.
- REQ-031: thresh=20, in_bus=16'h5555 for one cycle, then 0 -> spike=1 exactly 2 edges after presentation; mem=0; refractory=1 for 2 cycles; spike_cnt=1.
- REQ-032: Leak: thresh=200, in_bus=16'h0008 one cycle, then 0 -> mem sequence 8, 7, 7, 7 (stable because 7>>3=0).
- REQ-033: Saturation: thresh=0, in_bus=16'hFFFF held -> mem 60, 113, 159, 200, 235, 255, 255; spike never asserted.
- REQ-034: Mask: in_en=4'b0001, in_bus=16'hFFFF, thresh=15 -> spike after 2 edges; with in_en=4'b0000, no spike and mem stays 0.
- REQ-035: Refractory period: thresh=20, in_bus=16'h5555 held -> spike every 3rd cycle; spike_cnt wraps 255 -> 0 after 256 spikes; reset asserted during REFRACT -> refractory=0, mem=0 on the next edge.
